// File: rtl/lb_pkg.sv
// Shared load-balancer types and default dispatcher parameters.
// Consumed by region_dispatcher and the upstream load balancer.
package lb_pkg;

    localparam int DEF_HTTP_META_WIDTH   = 8;
    localparam int DEF_OPERATOR_ID_WIDTH = 2;
    localparam int DEF_N_REGIONS         = 4;
    localparam int DEF_QDEPTH            = 4;
    localparam int DEF_PNTR_BITS         = $clog2(DEF_QDEPTH);

    typedef struct packed {
        logic [DEF_OPERATOR_ID_WIDTH-1:0] oid;
        logic [DEF_PNTR_BITS-1:0]         load;
    } region_stat_t;

endpackage

// File: rtl/dispatch_fifo.sv
// Per-region FIFO: power-of-two depth, count in 0..QDEPTH.
// A full queue refuses pushes even when it pops in the same cycle.
module dispatch_fifo #(
    parameter  int WIDTH  = 8,
    parameter  int QDEPTH = 4,
    localparam int PB     = $clog2(QDEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [PB:0]      o_count
);

    logic [WIDTH-1:0] r_mem [QDEPTH];
    logic [PB-1:0]    r_wr;
    logic [PB-1:0]    r_rd;
    logic [PB:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (PB+1)'(QDEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (!i_rst && w_do_push) begin
            r_mem[r_wr] <= i_data;
        end
    end

    // Pointers wrap naturally because QDEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/region_dispatcher.sv
// Steers meta beats into per-region queues; out-of-range targets are dropped.
// Define DISPATCH_STATS_REG_EN to register region_stats_out (one-cycle lag).
module region_dispatcher
    import lb_pkg::*;
#(
    parameter int HTTP_META_WIDTH   = DEF_HTTP_META_WIDTH,
    parameter int OPERATOR_ID_WIDTH = DEF_OPERATOR_ID_WIDTH,
    parameter int N_REGIONS         = DEF_N_REGIONS,
    parameter int QDEPTH            = DEF_QDEPTH,
    localparam int PNTR_BITS        = $clog2(QDEPTH),
    localparam int LBW              = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1,
    localparam int SW               = OPERATOR_ID_WIDTH + PNTR_BITS
) (
    input  logic                                   aclk,
    input  logic                                   areset,
    input  logic                                   meta_in_tvalid,
    output logic                                   meta_in_tready,
    input  logic [HTTP_META_WIDTH-1:0]             meta_in_tdata,
    input  logic [LBW-1:0]                         lb_ctrl,
    input  logic [N_REGIONS*OPERATOR_ID_WIDTH-1:0] region_oid,
    output logic [N_REGIONS-1:0]                   region_out_tvalid,
    input  logic [N_REGIONS-1:0]                   region_out_tready,
    output logic [N_REGIONS*HTTP_META_WIDTH-1:0]   region_out_tdata,
    output logic [N_REGIONS*SW-1:0]                region_stats_out,
    output logic [15:0]                            drop_cnt
);

    logic [N_REGIONS-1:0]    w_full;
    logic [N_REGIONS-1:0]    w_empty;
    logic [N_REGIONS-1:0]    w_push;
    logic [N_REGIONS*SW-1:0] w_stats;
    logic                    w_in_range;
    logic                    w_sel_full;
    logic                    w_accept;
    logic [15:0]             r_drop_cnt;

    always_comb begin
        w_in_range = 1'b0;
        w_sel_full = 1'b0;
        for (int r = 0; r < N_REGIONS; r++) begin
            if (int'(lb_ctrl) == r) begin
                w_in_range = 1'b1;
                w_sel_full = w_full[r];
            end
        end
    end

    assign meta_in_tready = !areset && (!w_in_range || !w_sel_full);
    assign w_accept       = meta_in_tvalid && meta_in_tready;

    for (genvar g = 0; g < N_REGIONS; g++) begin : g_region
        logic [PNTR_BITS:0]   w_count;
        logic [PNTR_BITS-1:0] w_load;

        assign w_push[g] = w_accept && (int'(lb_ctrl) == g);

        dispatch_fifo #(
            .WIDTH  (HTTP_META_WIDTH),
            .QDEPTH (QDEPTH)
        ) u_fifo (
            .i_clk   (aclk),
            .i_rst   (areset),
            .i_push  (w_push[g]),
            .i_pop   (region_out_tready[g]),
            .i_data  (meta_in_tdata),
            .o_data  (region_out_tdata[g*HTTP_META_WIDTH +: HTTP_META_WIDTH]),
            .o_full  (w_full[g]),
            .o_empty (w_empty[g]),
            .o_count (w_count)
        );

        assign region_out_tvalid[g] = !w_empty[g];
        // A full queue (count == QDEPTH) saturates to the widest load code.
        assign w_load = w_count[PNTR_BITS] ? '1 : w_count[PNTR_BITS-1:0];
        assign w_stats[g*SW +: SW] =
            {region_oid[g*OPERATOR_ID_WIDTH +: OPERATOR_ID_WIDTH], w_load};
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_drop_cnt <= '0;
        end else if (w_accept && !w_in_range && r_drop_cnt != 16'hFFFF) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign drop_cnt = r_drop_cnt;

`ifdef DISPATCH_STATS_REG_EN
    logic [N_REGIONS*SW-1:0] r_stats;

    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int r = 0; r < N_REGIONS; r++) begin
                r_stats[r*SW +: SW] <=
                    {region_oid[r*OPERATOR_ID_WIDTH +: OPERATOR_ID_WIDTH],
                     {PNTR_BITS{1'b0}}};
            end
        end else begin
            r_stats <= w_stats;
        end
    end

    assign region_stats_out = r_stats;
`else
    assign region_stats_out = w_stats;
`endif

endmodule
